// File: rtl/timing_pkg.sv
// timing_pkg: shared measurement struct, 1080p defaults and lock limits for timing_probe.
package timing_pkg;
  localparam int H_WIDTH_DEF = 1920;
  localparam int H_START_DEF = 2008;
  localparam int H_TOTAL_DEF = 2200;
  localparam int V_HEIGHT_DEF = 1080;
  localparam int CW_DEF = 12;
  localparam int CW_MAX = 16;
  localparam int LOCK_FRAMES_MAX = 15;
  localparam int LCW = 4;
  typedef struct packed {
    logic [CW_MAX-1:0] width;
    logic [CW_MAX-1:0] start;
    logic [CW_MAX-1:0] total;
    logic [CW_MAX-1:0] height;
  } meas_t;
endpackage

// File: rtl/edge_det.sv
// edge_det: two-flop sampler with single-cycle rise/fall strobes.
module edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic s1, s2;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) {s1, s2} <= 2'b00;
    else {s1, s2} <= {d, s1};
  assign rise = s1 & ~s2;
  assign fall = ~s1 & s2;
endmodule

// File: rtl/timing_probe.sv
// timing_probe: measures hs/vs/de timing per frame and publishes it with lock/match status.
// Define PROBE_TIMEOUT_EN to add a vs watchdog that drops lock when frames stop arriving.
module timing_probe
  import timing_pkg::*;
#(
  parameter int H_WIDTH = H_WIDTH_DEF,
  parameter int H_START = H_START_DEF,
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int V_HEIGHT = V_HEIGHT_DEF,
  parameter int CW = CW_DEF,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          hs_i,
  input  logic          vs_i,
  input  logic          de_i,
  output logic [CW-1:0] h_width_o,
  output logic [CW-1:0] h_start_o,
  output logic [CW-1:0] h_total_o,
  output logic [CW-1:0] v_height_o,
  output logic          valid_o,
  output logic          locked_o,
  output logic          match_o,
  output logic          frame_o
);
  localparam logic [CW-1:0] MAX = '1;
  localparam logic [LCW-1:0] LF = LCW'(LOCK_FRAMES);
  localparam meas_t EXP = '{width: CW_MAX'(H_WIDTH), start: CW_MAX'(H_START),
                            total: CW_MAX'(H_TOTAL), height: CW_MAX'(V_HEIGHT)};
  logic hs_rise, vs_rise, de_rise, de_fall, unused_hs_fall, unused_vs_fall;
  logic [CW-1:0] cnt, lines, ref_w, ref_s, ref_t;
  logic w_ok, s_ok, t_ok, has_de, hs_arm, incons, ovf;
  logic good, same, tmo;
  logic [LCW-1:0] lock_cnt, lock_nx;
  meas_t pub, meas;

  edge_det u_hs (.clk_i(clk_i), .rst_i(rst_i), .d(hs_i), .rise(hs_rise), .fall(unused_hs_fall));
  edge_det u_vs (.clk_i(clk_i), .rst_i(rst_i), .d(vs_i), .rise(vs_rise), .fall(unused_vs_fall));
  edge_det u_de (.clk_i(clk_i), .rst_i(rst_i), .d(de_i), .rise(de_rise), .fall(de_fall));

  // Per-field references: start only becomes known after de falls, so each field locks in on its own first sample.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cnt <= '0;
      lines <= '0;
      {ref_w, ref_s, ref_t} <= '0;
      {w_ok, s_ok, t_ok, has_de, hs_arm, incons, ovf} <= '0;
    end else begin
      cnt <= de_rise ? CW'(1) : cnt == MAX ? cnt : cnt + CW'(1);
      if (!de_rise && cnt == MAX) ovf <= 1'b1;
      if (de_fall) begin
        lines <= lines == MAX ? lines : lines + CW'(1);
        if (lines == MAX) ovf <= 1'b1;
        w_ok <= 1'b1;
        if (!w_ok) ref_w <= cnt;
        else if (cnt != ref_w) incons <= 1'b1;
      end
      if (hs_rise && hs_arm) begin
        hs_arm <= 1'b0;
        s_ok <= 1'b1;
        if (!s_ok) ref_s <= cnt;
        else if (cnt != ref_s) incons <= 1'b1;
      end
      if (de_rise) begin
        hs_arm <= 1'b1;
        has_de <= 1'b1;
      end
      if (de_rise && has_de) begin
        t_ok <= 1'b1;
        if (!t_ok) ref_t <= cnt;
        else if (cnt != ref_t) incons <= 1'b1;
      end
      if (vs_rise) begin
        lines <= '0;
        {ref_w, ref_s, ref_t} <= '0;
        {w_ok, s_ok, t_ok, incons, ovf} <= '0;
        has_de <= de_rise;
        hs_arm <= de_rise;
      end
    end

  always_comb begin
    meas = '{width: CW_MAX'(ref_w), start: CW_MAX'(ref_s), total: CW_MAX'(ref_t), height: CW_MAX'(lines)};
    good = lines >= CW'(2) && !incons && !ovf;
    same = valid_o && meas == pub;
    lock_nx = !same ? LCW'(1) : lock_cnt >= LF ? LF : lock_cnt + LCW'(1);
  end

`ifdef PROBE_TIMEOUT_EN
  logic [CW+9:0] wd;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) wd <= '0;
    else wd <= vs_rise ? '0 : wd + 1'b1;
  assign tmo = &wd;
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      pub <= '0;
      lock_cnt <= '0;
      {valid_o, locked_o, match_o, frame_o} <= '0;
    end else begin
      frame_o <= vs_rise | tmo;
      if (vs_rise && good) begin
        pub <= meas;
        valid_o <= 1'b1;
        lock_cnt <= lock_nx;
        locked_o <= lock_nx >= LF;
        match_o <= lock_nx >= LF && meas == EXP;
      end else if (vs_rise || tmo) begin
        lock_cnt <= '0;
        {valid_o, locked_o, match_o} <= '0;
      end
    end

  assign h_width_o = pub.width[CW-1:0];
  assign h_start_o = pub.start[CW-1:0];
  assign h_total_o = pub.total[CW-1:0];
  assign v_height_o = pub.height[CW-1:0];
endmodule

// File: tb/tb_timing_probe.sv
// tb_timing_probe: randomized frames checked against a frame-level model of timing_probe.
module tb_timing_probe;
  localparam int HW = 16, HS = 20, HT = 24, VH = 8, CW = 8, LF = 2;
  logic clk = 0, rst = 1, hs = 0, vs = 0, de = 0;
  logic [CW-1:0] h_width, h_start, h_total, v_height;
  logic valid, locked, match, frame;
  int n_tests = 0, n_fail = 0, n_frame = 0;
  int exp_w = 0, exp_s = 0, exp_t = 0, exp_v = 0, exp_valid = 0, exp_lock = 0, pend_ovf = 0;

  timing_probe #(.H_WIDTH(HW), .H_START(HS), .H_TOTAL(HT), .V_HEIGHT(VH), .CW(CW), .LOCK_FRAMES(LF)) dut (
    .clk_i(clk), .rst_i(rst), .hs_i(hs), .vs_i(vs), .de_i(de),
    .h_width_o(h_width), .h_start_o(h_start), .h_total_o(h_total), .v_height_o(v_height),
    .valid_o(valid), .locked_o(locked), .match_o(match), .frame_o(frame));

  always #5 clk = ~clk;
  always @(negedge clk) if (frame) n_frame++;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    int lk;
    lk = exp_lock >= LF;
    check({tag, ".valid"}, valid, exp_valid);
    check({tag, ".locked"}, locked, lk);
    check({tag, ".match"}, match, lk && exp_w == HW && exp_s == HS && exp_t == HT && exp_v == VH);
    check({tag, ".width"}, h_width, exp_w);
    check({tag, ".start"}, h_start, exp_s);
    check({tag, ".total"}, h_total, exp_t);
    check({tag, ".height"}, v_height, exp_v);
  endtask

  task automatic line(input int w, input int tot);
    for (int c = 0; c < tot; c++) begin
      de = c < w;
      hs = c >= HS && c < HS + 2;
      tick();
    end
    de = 0;
    hs = 0;
  endtask

  task automatic vsync();
    repeat (4) tick();
    vs = 1;
    repeat (4) tick();
    vs = 0;
    repeat (8) tick();
  endtask

  task automatic model_reset();
    {exp_w, exp_s, exp_t, exp_v, exp_valid, exp_lock, pend_ovf} = '0;
  endtask

  // Frame is publishable when it has >=2 lines, all widths agree and no line outruns the counter.
  task automatic frame_run(input string tag, input int w, input int nl, input int bad, input int bad_w);
    int f0, good, same, wl, tot;
    int ws[$];
    f0 = n_frame;
    for (int l = 0; l < nl; l++) begin
      wl = (l == bad) ? bad_w : w;
      ws.push_back(wl);
      tot = wl + 4 > HT ? wl + 4 : HT;
      line(wl, tot);
    end
    vsync();
    good = nl >= 2 && pend_ovf == 0;
    foreach (ws[i]) if (ws[i] != ws[0] || ws[i] + 4 > 255) good = 0;
    pend_ovf = 0;
    if (good != 0) begin
      same = exp_valid != 0 && exp_w == w && exp_s == HS && exp_t == HT && exp_v == nl;
      exp_lock = same ? (exp_lock < LF ? exp_lock + 1 : LF) : 1;
      exp_w = w; exp_s = HS; exp_t = HT; exp_v = nl;
      exp_valid = 1;
    end else begin
      exp_valid = 0;
      exp_lock = 0;
    end
    check_state(tag);
    check({tag, ".pulse"}, n_frame - f0, 1);
  endtask

  initial begin
    int f0, w, nl, bad;
    repeat (3) tick();
    check_state("reset");
    check("reset.frame", frame, 0);
    rst = 0;
    repeat (5) tick();
    for (int i = 0; i < 3; i++) frame_run("clean", HW, VH, -1, 0);
    for (int i = 0; i < 3; i++) frame_run("w18", 18, VH, -1, 0);
    for (int i = 0; i < 2; i++) frame_run("relock", HW, VH, -1, 0);
    frame_run("bad5", HW, VH, 4, 17);
    frame_run("after_bad", HW, VH, -1, 0);
    frame_run("after_bad2", HW, VH, -1, 0);
    frame_run("stuck", HW, VH, 2, 300);
    frame_run("one_line", HW, 1, -1, 0);
    for (int i = 0; i < 24; i++) begin
      w = $urandom_range(0, 3) == 0 ? $urandom_range(8, 19) : ($urandom_range(0, 1) ? HW : 18);
      nl = $urandom_range(0, 3) == 0 ? $urandom_range(1, 10) : VH;
      bad = $urandom_range(0, 4) == 0 ? $urandom_range(0, nl - 1) : -1;
      frame_run("rand", w, nl, bad, w + $urandom_range(1, 3));
    end
    f0 = n_frame;
    repeat (1000) tick();
    check_state("hold");
    check("hold.pulse", n_frame - f0, 0);
    pend_ovf = 1;
    frame_run("post_idle", HW, VH, -1, 0);
    frame_run("lock_a", HW, VH, -1, 0);
    frame_run("lock_b", HW, VH, -1, 0);
    check("pre_rst.locked", locked, 1);
    for (int l = 0; l < 2; l++) line(HW, HT);
    for (int c = 0; c < HT; c++) begin
      de = c < HW;
      hs = c >= HS && c < HS + 2;
      if (c == 8) begin
        #2 rst = 1;
        #1 model_reset();
        check_state("async_rst");
      end
      if (c == 10) rst = 0;
      tick();
    end
    de = 0;
    hs = 0;
    for (int l = 3; l < VH; l++) line(HW, HT);
    f0 = n_frame;
    vsync();
    check_state("partial");
    check("partial.pulse", n_frame - f0, 1);
    frame_run("rst_full1", HW, VH, -1, 0);
    frame_run("rst_full2", HW, VH, -1, 0);
`ifdef PROBE_TIMEOUT_EN
    f0 = n_frame;
    repeat ((1 << (CW + 10)) + 50) tick();
    exp_valid = 0;
    exp_lock = 0;
    check_state("timeout");
    check("timeout.pulse", n_frame - f0, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
